mod256_up_counter_ctrl: RTL and testbench

MOD256_UP_COUNTER_CTRL -- requirements
Module: mod256_up_counter_ctrl

---
 rtl/mod256_up_counter_ctrl.sv | 78 +++++++
 tb/tb_mod256_up_counter_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mod256_up_counter_ctrl.sv
// Two-state (IDLE/RUN) controller around an 8-bit mod-256 up counter with
// preset load, terminal-count detection and registered done/wrap pulses.
module mod256_up_counter_ctrl #(
   parameter bit AUTO_RESTART = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       stop,
   input  logic       load,
   input  logic [7:0] load_value,
   input  logic [7:0] limit,
   output logic [7:0] counter_output,
   output logic       busy,
   output logic       done,
   output logic       wrap
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [7:0] r_cnt;
   logic [7:0] w_cnt_nxt;
   logic       r_done;
   logic       w_done_nxt;
   logic       r_wrap;
   logic       w_wrap_nxt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= 8'h00;
         r_done  <= 1'b0;
         r_wrap  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_done  <= w_done_nxt;
         r_wrap  <= w_wrap_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_done_nxt  = 1'b0;
      w_wrap_nxt  = 1'b0;
      if (r_state == IDLE) begin
         // load outranks start; start+stop together is treated as no request
         if (load) begin
            w_cnt_nxt = load_value;
         end else if (start && !stop) begin
            w_state_nxt = RUN;
         end
      end else begin
         if (stop) begin
            w_state_nxt = IDLE;
         end else if (r_cnt == limit) begin
            w_done_nxt = 1'b1;
            if (AUTO_RESTART) begin
               w_cnt_nxt = 8'h00;
            end else begin
               w_state_nxt = IDLE;
            end
         end else begin
            w_cnt_nxt  = r_cnt + 8'd1;
            w_wrap_nxt = (r_cnt == 8'hFF);
         end
      end
   end

   assign counter_output = r_cnt;
   assign busy           = (r_state == RUN);
   assign done           = r_done;
   assign wrap           = r_wrap;

endmodule

// File: tb/tb_mod256_up_counter_ctrl.sv
// Bench for mod256_up_counter_ctrl: one instance per AUTO_RESTART setting,
// directed vector table, hand sequences and randomized run against a model.
module tb_mod256_up_counter_ctrl;

   logic       clk;
   logic       reset;
   logic       start;
   logic       stop;
   logic       load;
   logic [7:0] load_value;
   logic [7:0] limit;
   logic [7:0] cnt0, cnt1;
   logic       busy0, busy1, done0, done1, wrap0, wrap1;

   int n_cmp = 0;
   int n_bad = 0;

   mod256_up_counter_ctrl #(.AUTO_RESTART(1'b0)) u_dut0 (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .load(load),
      .load_value(load_value), .limit(limit),
      .counter_output(cnt0), .busy(busy0), .done(done0), .wrap(wrap0)
   );

   mod256_up_counter_ctrl #(.AUTO_RESTART(1'b1)) u_dut1 (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .load(load),
      .load_value(load_value), .limit(limit),
      .counter_output(cnt1), .busy(busy1), .done(done1), .wrap(wrap1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model: index 0 = return-to-idle, index 1 = auto-restart.
   bit m_run  [2];
   int m_cnt  [2];
   bit m_done [2];
   bit m_wrap [2];

   typedef struct {
      logic       st, sp, ld;
      logic [7:0] lv, lim;
      logic [7:0] cnt;
      logic       bsy, dn, wr;
   } vec_t;
   vec_t vq[$];

   task automatic addv(input logic st, sp, ld, input logic [7:0] lv, lim,
                       input logic [7:0] cnt, input logic bsy, dn, wr);
      vec_t v;
      v.st = st; v.sp = sp; v.ld = ld; v.lv = lv; v.lim = lim;
      v.cnt = cnt; v.bsy = bsy; v.dn = dn; v.wr = wr;
      vq.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_run[k] = 0; m_cnt[k] = 0; m_done[k] = 0; m_wrap[k] = 0;
      end
   endtask

   task automatic model_step(input int k, input bit ar);
      bit nd, nw;
      nd = 0; nw = 0;
      if (!m_run[k]) begin
         if (load) m_cnt[k] = int'(load_value);
         else if (start && !stop) m_run[k] = 1;
      end else if (stop) begin
         m_run[k] = 0;
      end else if (m_cnt[k] == int'(limit)) begin
         nd = 1;
         if (ar) m_cnt[k] = 0;
         else    m_run[k] = 0;
      end else begin
         nw = (m_cnt[k] == 255);
         m_cnt[k] = (m_cnt[k] + 1) % 256;
      end
      m_done[k] = nd;
      m_wrap[k] = nw;
   endtask

   task automatic chk_model0();
      chk("m0_cnt",  cnt0,  m_cnt[0]);
      chk("m0_busy", busy0, m_run[0]);
      chk("m0_done", done0, m_done[0]);
      chk("m0_wrap", wrap0, m_wrap[0]);
   endtask

   task automatic chk_model1();
      chk("m1_cnt",  cnt1,  m_cnt[1]);
      chk("m1_busy", busy1, m_run[1]);
      chk("m1_done", done1, m_done[1]);
      chk("m1_wrap", wrap1, m_wrap[1]);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step(0, 1'b0);
      model_step(1, 1'b1);
      #1;
   endtask

   task automatic idle_inputs();
      start = 0; stop = 0; load = 0;
   endtask

   task automatic pulse_reset();
      reset = 1;
      model_reset();
      #1;
      reset = 0;
   endtask

   initial begin
      reset = 1; start = 0; stop = 0; load = 0; load_value = 8'h00; limit = 8'h00;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cnt0", cnt0, 8'h00);  chk("rst_busy0", busy0, 1'b0);
      chk("rst_done0", done0, 1'b0); chk("rst_wrap0", wrap0, 1'b0);
      chk("rst_cnt1", cnt1, 8'h00);  chk("rst_busy1", busy1, 1'b0);
      reset = 0;

      //   st sp ld  lv     lim    cnt  bsy dn wr
      addv(1, 0, 0, 8'h00, 8'h03, 8'h00, 1, 0, 0);
      addv(0, 0, 0, 8'h00, 8'h03, 8'h01, 1, 0, 0);
      addv(0, 0, 0, 8'h00, 8'h03, 8'h02, 1, 0, 0);
      addv(0, 0, 0, 8'h00, 8'h03, 8'h03, 1, 0, 0);
      addv(0, 0, 0, 8'h00, 8'h03, 8'h03, 0, 1, 0);
      addv(0, 0, 0, 8'h00, 8'h03, 8'h03, 0, 0, 0);
      addv(1, 0, 1, 8'hFE, 8'h01, 8'hFE, 0, 0, 0);
      addv(1, 1, 0, 8'h00, 8'h01, 8'hFE, 0, 0, 0);
      addv(1, 0, 0, 8'h00, 8'h01, 8'hFE, 1, 0, 0);
      addv(0, 0, 0, 8'h00, 8'h01, 8'hFF, 1, 0, 0);
      addv(0, 0, 0, 8'h00, 8'h01, 8'h00, 1, 0, 1);
      addv(0, 0, 0, 8'h00, 8'h01, 8'h01, 1, 0, 0);
      addv(0, 0, 0, 8'h00, 8'h01, 8'h01, 0, 1, 0);
      addv(0, 0, 1, 8'h04, 8'h05, 8'h04, 0, 0, 0);
      addv(1, 0, 0, 8'h00, 8'h05, 8'h04, 1, 0, 0);
      addv(0, 0, 0, 8'h00, 8'h05, 8'h05, 1, 0, 0);
      addv(0, 1, 0, 8'h00, 8'h05, 8'h05, 0, 0, 0);
      addv(1, 0, 0, 8'h00, 8'h05, 8'h05, 1, 0, 0);
      addv(0, 0, 0, 8'h00, 8'h05, 8'h05, 0, 1, 0);
      addv(0, 0, 1, 8'h10, 8'h20, 8'h10, 0, 0, 0);
      addv(1, 0, 0, 8'h00, 8'h20, 8'h10, 1, 0, 0);
      addv(1, 0, 1, 8'h99, 8'h20, 8'h11, 1, 0, 0);
      addv(0, 0, 0, 8'h00, 8'h11, 8'h11, 0, 1, 0);

      foreach (vq[i]) begin
         start = vq[i].st; stop = vq[i].sp; load = vq[i].ld;
         load_value = vq[i].lv; limit = vq[i].lim;
         tick();
         chk($sformatf("vec%0d_cnt", i),  cnt0,  vq[i].cnt);
         chk($sformatf("vec%0d_busy", i), busy0, vq[i].bsy);
         chk($sformatf("vec%0d_done", i), done0, vq[i].dn);
         chk($sformatf("vec%0d_wrap", i), wrap0, vq[i].wr);
         chk_model1();
      end
      idle_inputs();

      // Auto-restart cycling with limit 2
      begin
         logic [7:0] ecnt [7];
         logic       edn  [7];
         ecnt = '{8'h00, 8'h01, 8'h02, 8'h00, 8'h01, 8'h02, 8'h00};
         edn  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
         pulse_reset();
         limit = 8'h02; start = 1;
         for (int i = 0; i < 7; i++) begin
            tick();
            start = 0;
            chk($sformatf("ar%0d_cnt", i),  cnt1,  ecnt[i]);
            chk($sformatf("ar%0d_done", i), done1, edn[i]);
            chk($sformatf("ar%0d_wrap", i), wrap1, 1'b0);
            chk($sformatf("ar%0d_busy", i), busy1, 1'b1);
            chk_model0();
         end
      end

      // Asynchronous reset while running at 0x40
      pulse_reset();
      load = 1; load_value = 8'h3E; limit = 8'hFF;
      tick();
      load = 0; start = 1;
      tick();
      start = 0;
      tick();
      tick();
      chk("pre_rst_cnt", cnt0, 8'h40);
      chk("pre_rst_busy", busy0, 1'b1);
      #2;
      reset = 1; start = 1; load = 1; load_value = 8'hAA;
      model_reset();
      #1;
      chk("arst_cnt0", cnt0, 8'h00);  chk("arst_busy0", busy0, 1'b0);
      chk("arst_done0", done0, 1'b0); chk("arst_wrap0", wrap0, 1'b0);
      chk("arst_cnt1", cnt1, 8'h00);  chk("arst_busy1", busy1, 1'b0);
      @(posedge clk);
      #1;
      chk("arst_hold_cnt", cnt0, 8'h00);
      chk("arst_hold_busy", busy0, 1'b0);
      reset = 0;
      idle_inputs();
      tick();
      chk("post_rst_busy", busy0, 1'b0);
      chk("post_rst_done", done0, 1'b0);
      chk("post_rst_cnt", cnt0, 8'h00);
      start = 1; limit = 8'h02;
      tick();
      start = 0;
      chk("post_rst_start", busy0, 1'b1);
      chk_model0();
      chk_model1();

      // Randomized run against the model
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 79) == 0) begin
            pulse_reset();
            chk_model0();
            chk_model1();
         end
         start = ($urandom_range(0, 2) == 0);
         stop  = ($urandom_range(0, 9) == 0);
         load  = ($urandom_range(0, 5) == 0);
         load_value = ($urandom_range(0, 1) == 1) ? 8'(8'hF8 + $urandom_range(0, 7))
                                                   : 8'($urandom);
         if ($urandom_range(0, 3) == 0) limit = 8'($urandom);
         else if ($urandom_range(0, 1) == 0)
            limit = 8'((m_cnt[0] + $urandom_range(0, 6)) % 256);
         tick();
         chk_model0();
         chk_model1();
         chk("excl0", {31'd0, done0 & wrap0}, 32'd0);
      end
      idle_inputs();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
